// File: rtl/pkt_rr_sched.sv
// Packet-level round-robin scheduler.
// Shares one output stream between N per-source packet FIFOs. A grant is held
// for a whole packet. A length watchdog cuts off runaway packets and drains
// the rest of them so that one faulty source cannot lock the output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; searching ptr+1 .. ptr+N for the next requester
// ST_XFER  | granted source forwards beats to the output
// ST_DRAIN | truncated packet: pop the source until its last beat, no output
// ST_GAP   | idle spacing after a packet end; nothing is granted
module pkt_rr_sched #(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int MAX_LEN = 1518,
    parameter int GAP     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_v_i,
    input  logic [N*W-1:0]   req_d_i,
    input  logic [N-1:0]     req_last_i,
    output logic [N-1:0]     req_ack_o,
    output logic             out_v_o,
    output logic [W-1:0]     out_d_o,
    output logic             out_last_o,
    input  logic             out_rdy_i,
    output logic [N-1:0]     grant_o,
    output logic             busy_o,
    output logic             abort_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IW-1:0] PTR_RST  = IW'(N - 1);
    localparam logic [LW-1:0] LEN_TC   = LW'(MAX_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_GAP
    } state_t;

    // With no gap configured a finished packet goes straight back to arbitration.
    localparam state_t ST_END = (GAP > 0) ? ST_GAP : ST_IDLE;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [IW-1:0]   gidx_q;
    logic [IW-1:0]   ptr_q;
    logic [LW-1:0]   len_q;
    logic [GW-1:0]   gap_q;
    logic            abort_q;

    logic            sel_found_d;
    logic [IW-1:0]   sel_idx_d;
    logic [IW-1:0]   cand;
    logic [W-1:0]    req_d_arr [N];

    logic            cur_v;
    logic            cur_last;
    logic            len_tc;
    logic            in_xfer;
    logic            in_drain;
    logic            accept;

    // Unpack the flat data bus into one word per source.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_d_arr[i] = req_d_i[i*W +: W];
        end
    end

    // Round-robin search starting one past the last owner.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr_q) + i) % N);
            if (!sel_found_d && req_v_i[cand]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = cand;
            end
        end
    end

    assign cur_v    = req_v_i[gidx_q];
    assign cur_last = req_last_i[gidx_q];
    assign len_tc   = (len_q == LEN_TC);
    assign in_xfer  = (state_q == ST_XFER);
    assign in_drain = (state_q == ST_DRAIN);

    // The output is a straight mux of the owner, so out_d stays put while the
    // source holds its data during a downstream stall.
    assign out_v_o    = in_xfer & cur_v;
    assign out_d_o    = req_d_arr[gidx_q];
    assign out_last_o = in_xfer & (cur_last | len_tc);
    assign accept     = out_v_o & out_rdy_i;

    // Pop the owner on an accepted beat, or unconditionally while draining.
    always_comb begin
        req_ack_o = '0;
        if ((in_xfer && out_rdy_i) || in_drain) begin
            req_ack_o[gidx_q] = cur_v;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign abort_o = abort_q;

    // Scheduler state machine with registered grant, length and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_RST;
            len_q   <= '0;
            gap_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found_d) begin
                        grant_q            <= '0;
                        grant_q[sel_idx_d] <= 1'b1;
                        gidx_q             <= sel_idx_d;
                        ptr_q              <= sel_idx_d;
                        state_q            <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept) begin
                        // A real last beat wins over the watchdog on the same beat.
                        if (cur_last) begin
                            len_q   <= '0;
                            grant_q <= '0;
                            gap_q   <= GAP_LOAD;
                            state_q <= ST_END;
                        end else if (len_tc) begin
                            len_q   <= '0;
                            abort_q <= 1'b1;
                            state_q <= ST_DRAIN;
                        end else begin
                            len_q <= len_q + LW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cur_v && cur_last) begin
                        grant_q <= '0;
                        gap_q   <= GAP_LOAD;
                        state_q <= ST_END;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_o));
    a_ack_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack_o));

endmodule

// File: tb/tb_pkt_rr_sched.sv
// Directed bench for pkt_rr_sched: per-source FIFO models feed the DUT,
// expected beats and grants are queued as stimulus is loaded and are
// compared as the DUT produces them.
module tb_pkt_rr_sched;

    localparam int W       = 8;
    localparam int N       = 4;
    localparam int MAX_LEN = 4;
    localparam int GAP     = 1;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_v;
    logic [N*W-1:0]   req_d;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ack;
    logic             out_v;
    logic [W-1:0]     out_d;
    logic             out_last;
    logic             out_rdy;
    logic [N-1:0]     grant;
    logic             busy;
    logic             abort;

    logic [8:0]       src_q [N][$];
    logic [8:0]       exp_q [$];
    logic [N-1:0]     exp_g [$];

    int               checks;
    int               errors;
    int               beats;
    int               lasts;
    int               drained;
    int               aborts;
    int               ack_cnt [N];
    logic [N-1:0]     grant_prev;

    pkt_rr_sched #(
        .W(W),
        .N(N),
        .MAX_LEN(MAX_LEN),
        .GAP(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_v_i    (req_v),
        .req_d_i    (req_d),
        .req_last_i (req_last),
        .req_ack_o  (req_ack),
        .out_v_o    (out_v),
        .out_d_o    (out_d),
        .out_last_o (out_last),
        .out_rdy_i  (out_rdy),
        .grant_o    (grant),
        .busy_o     (busy),
        .abort_o    (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present the head of every source FIFO model on the request bus.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_v[i]        = 1'b1;
                req_d[i*W +: W] = src_q[i][0][7:0];
                req_last[i]     = src_q[i][0][8];
            end else begin
                req_v[i]        = 1'b0;
                req_d[i*W +: W] = '0;
                req_last[i]     = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        if (out_v && out_rdy) begin
            beats++;
            if (out_last) lasts++;
            if (exp_q.size() == 0) begin
                chk("beat_unexpected", 32'(out_v), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {23'd0, out_last, out_d}, {23'd0, e});
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) ack_cnt[i]++;
        end
        if ((|req_ack) && !out_v) drained++;
        if (abort) aborts++;
        if (grant != '0 && grant_prev == '0) begin
            if (exp_g.size() == 0) begin
                chk("grant_unexpected", 32'(grant), 32'd0);
            end else begin
                chk("grant_order", 32'(grant), 32'(exp_g.pop_front()));
            end
        end
        grant_prev = grant;
    endtask

    // One clock: observe just after the falling edge, pop what the DUT acked
    // just after the rising edge, return on the next falling edge.
    task automatic tick();
        logic [N-1:0] ack_s;
        #1;
        ack_s = req_ack;
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
        @(negedge clk);
    endtask

    task automatic load_pkt(input int src, input int n, input logic [7:0] base);
        logic [8:0] b;
        for (int k = 0; k < n; k++) begin
            b = {(k == n - 1), 8'(int'(base) + k)};
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_counts();
        beats   = 0;
        lasts   = 0;
        drained = 0;
        aborts  = 0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            tick();
            done = (exp_q.size() == 0) && (exp_g.size() == 0) && !busy;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() != 0) done = 1'b0;
            end
        end
        chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        grant_prev = '0;
        rst        = 1'b1;
        out_rdy    = 1'b1;
        req_v      = '0;
        req_d      = '0;
        req_last   = '0;
        clear_counts();
        @(negedge clk);
        tick();
        tick();

        // Reset values
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_out_v", 32'(out_v), 32'd0);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        tick();

        // Single source, 3-beat packet, one cycle of arbitration latency
        clear_counts();
        load_pkt(0, 3, 8'h10);
        exp_g.push_back(4'b0001);
        drive();
        #1;
        chk("t1_arb_out_v", 32'(out_v), 32'd0);
        tick();
        chk("t1_out_v", 32'(out_v), 32'd1);
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_d0", 32'(out_d), 32'h10);
        tick();
        tick();
        chk("t1_last", 32'(out_last), 32'd1);
        chk("t1_d2", 32'(out_d), 32'h12);
        tick();
        chk("t1_gap_busy", 32'(busy), 32'd1);
        chk("t1_gap_out_v", 32'(out_v), 32'd0);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_beats", 32'(beats), 32'd3);
        chk("t1_lasts", 32'(lasts), 32'd1);
        chk("t1_acks", 32'(ack_cnt[0]), 32'd3);

        // Fairness among sources 0, 1 and 3
        reset_dut();
        clear_counts();
        for (int r = 0; r < 2; r++) begin
            load_pkt(0, 2, 8'(8'h20 + r * 8'h08));
            load_pkt(1, 2, 8'(8'h24 + r * 8'h08));
            load_pkt(3, 2, 8'(8'h26 + r * 8'h08));
            exp_g.push_back(4'b0001);
            exp_g.push_back(4'b0010);
            exp_g.push_back(4'b1000);
        end
        drive();
        run_until_idle(100, "t2");
        chk("t2_src2_acks", 32'(ack_cnt[2]), 32'd0);
        chk("t2_beats", 32'(beats), 32'd12);
        chk("t2_lasts", 32'(lasts), 32'd6);

        // Backpressure during a 4-beat packet
        clear_counts();
        load_pkt(0, 4, 8'h30);
        exp_g.push_back(4'b0001);
        out_rdy = 1'b1;
        drive();
        tick();
        chk("t3_d0", 32'(out_d), 32'h30);
        tick();
        out_rdy = 1'b0;
        tick();
        chk("t3_stall1_d", 32'(out_d), 32'h31);
        chk("t3_stall1_v", 32'(out_v), 32'd1);
        chk("t3_stall1_ack", 32'(req_ack), 32'd0);
        tick();
        chk("t3_stall2_d", 32'(out_d), 32'h31);
        chk("t3_stall2_ack", 32'(req_ack), 32'd0);
        out_rdy = 1'b1;
        tick();
        chk("t3_d2", 32'(out_d), 32'h32);
        run_until_idle(50, "t3");
        chk("t3_beats", 32'(beats), 32'd4);
        chk("t3_lasts", 32'(lasts), 32'd1);
        chk("t3_acks", 32'(ack_cnt[0]), 32'd4);

        // Watchdog truncation of a 7-beat packet, source 1 pending behind it
        clear_counts();
        for (int k = 0; k < 7; k++) begin
            src_q[2].push_back({(k == 6), 8'(8'h40 + k)});
        end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), 8'(8'h40 + k)});
        end
        exp_g.push_back(4'b0100);
        exp_g.push_back(4'b0010);
        drive();
        tick();
        load_pkt(1, 2, 8'h50);
        drive();
        run_until_idle(100, "t4");
        chk("t4_beats", 32'(beats), 32'd6);
        chk("t4_lasts", 32'(lasts), 32'd2);
        chk("t4_aborts", 32'(aborts), 32'd1);
        chk("t4_drained", 32'(drained), 32'd3);
        chk("t4_src2_acks", 32'(ack_cnt[2]), 32'd7);
        chk("t4_src1_acks", 32'(ack_cnt[1]), 32'd2);

        // Packet of exactly MAX_LEN beats ends normally
        clear_counts();
        load_pkt(3, 4, 8'h60);
        exp_g.push_back(4'b1000);
        drive();
        run_until_idle(50, "t5");
        chk("t5_beats", 32'(beats), 32'd4);
        chk("t5_lasts", 32'(lasts), 32'd1);
        chk("t5_aborts", 32'(aborts), 32'd0);
        chk("t5_drained", 32'(drained), 32'd0);

        // Reset in the middle of a 5-beat packet
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            src_q[0].push_back({(k == 4), 8'(8'h70 + k)});
        end
        exp_q.push_back({1'b0, 8'h70});
        exp_q.push_back({1'b0, 8'h71});
        exp_g.push_back(4'b0001);
        drive();
        tick();
        tick();
        chk("t6_beat2_d", 32'(out_d), 32'h71);
        rst = 1'b1;
        tick();
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_out_v", 32'(out_v), 32'd0);
        chk("t6_rst_ack", 32'(req_ack), 32'd0);
        rst = 1'b0;
        src_q[0].delete();
        load_pkt(0, 1, 8'h90);
        load_pkt(1, 1, 8'h91);
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0010);
        drive();
        tick();
        chk("t6_restart_grant", 32'(grant), 32'd1);
        run_until_idle(50, "t6");
        chk("t6_beats", 32'(beats), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
